line_fill_responder: RTL
========================

LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 SHALL have parameter WORD_WID, default 64, meaning the bits per memory word and per response beat.
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning the words per cache line (power of 2, >=2).
REQ-003 SHALL have parameter DEPTH, default 4096, meaning the memory depth in words (power of 2).
REQ-004 SHALL have parameter LATENCY, default 2, meaning the extra wait cycles before the first beat (>=0).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk_i input 1 clock; rst_ni input 1 async active-low reset.
REQ-006 SHALL have port req_valid_i  input  1  line-fill request valid.
REQ-007 SHALL have port req_ready_o  output  1  request accepted when high together with req_valid_i.
REQ-008 SHALL have port req_addr_i  input  32  byte address of the missed word.
REQ-009 SHALL have port rsp_valid_o  output  1  response beat valid.
REQ-010 SHALL have port rsp_ready_i  input  1  requester accepts the beat.
REQ-011 SHALL have port rsp_data_o  output  WORD_WID  beat data.
REQ-012 SHALL have port rsp_last_o  output  1  final beat of the line.
REQ-013 SHALL have port rsp_err_o  output  1  address out of range.
REQ-014 SHALL have ports wr_en_i (input, 1), wr_addr_i (input, log2(DEPTH)) and wr_data_i (input, WORD_WID), forming the backdoor word write port.

Function
REQ-015 SHALL derive word index W = req_addr_i[31:3]; bits [2:0] are ignored.
REQ-016 SHALL return the line containing W critical-word-first: beat k carries word {W[upper], (W[low]+k) mod LINE_WORDS} for k=0..LINE_WORDS-1, where low = log2(LINE_WORDS) bits; the offset wraps within the line.
REQ-017 SHALL assert rsp_err_o on every beat of a request with W >= DEPTH, with rsp_data_o = 0 and no memory read.
REQ-018 SHALL use FSM states IDLE, WAIT, SEND: IDLE->WAIT on request handshake; WAIT->SEND after LATENCY cycles (LATENCY=0 passes through WAIT in one cycle); SEND->IDLE on the handshake of the beat with rsp_last_o=1.
REQ-019 SHALL drive req_ready_o high only in IDLE; requests are never queued.
REQ-020 SHALL first assert rsp_valid_o exactly LATENCY+2 rising edges after the accepting edge.
REQ-021 SHALL hold rsp_data_o, rsp_last_o and rsp_err_o stable while rsp_valid_o=1 and rsp_ready_i=0; rsp_valid_o is never withdrawn before the handshake.
REQ-022 SHALL sustain one beat per cycle while rsp_ready_i stays high: a full line is LATENCY+1+LINE_WORDS cycles from accept to the last handshake.
REQ-023 SHALL assert rsp_last_o only on beat LINE_WORDS-1.
REQ-024 SHALL write wr_data_i to wr_addr_i on the clock edge when wr_en_i=1, in any state.
REQ-025 SHALL give a read and a write of the same word on the same edge read-first (old data); beats read after the write edge return the new data.

Reset
REQ-026 SHALL immediately force, while rst_ni=0: state IDLE, rsp_valid_o=0, rsp_last_o=0, rsp_err_o=0, rsp_data_o=0, req_ready_o=0, beat counter=0, wait counter=0.
REQ-027 SHALL drive req_ready_o=1 on the first edge after rst_ni deasserts.
REQ-028 SHALL abort a fill when reset asserts mid-fill, with no further beats for that request.
REQ-029 SHALL leave memory contents uninitialised by reset.

Structure
REQ-030 SHALL take WORD_WID, LINE_WORDS defaults and the state_t enum (IDLE, WAIT, SEND) from shared package cache_pkg, also used by the cache.
REQ-031 SHALL hold storage in one sub-module, sram_1r1w (synchronous read, one-cycle latency, read-first), instantiated once.
REQ-032 SHALL implement beat sequencing, wait counting and output hold registers in this module.

Verification
REQ-033 SHALL cover basic fill: LATENCY=2, mem[w]=w for w=0..15, request addr 0x20 with rsp_ready_i=1 -> valid at accept+4 edges, data 4,5,6,7 on consecutive cycles, last on 7.
REQ-034 SHALL cover wrap-around: request addr 0x38 (W=7) -> data 7,4,5,6, last on 6.
REQ-035 SHALL cover backpressure: rsp_ready_i low 3 cycles on beat 1 -> beat-1 data held, no beats lost or duplicated, req_ready_o low until last handshake.
REQ-036 SHALL cover error: DEPTH=4096, addr 0x0000_8000 (W=4096) -> 4 beats, rsp_err_o=1, data 0.
REQ-037 SHALL cover write hazard: during a fill of line 8..11, write mem[10]=0xAA at edge of beat-0 handshake -> beat 2 returns 0xAA.
REQ-038 SHALL cover reset mid-fill: rst_ni low after beat 1 -> rsp_valid_o drops immediately, req_ready_o=1 one edge after release, next request served normally.

Source files
------------

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared cache types and defaults: word/line geometry and the
//                line-fill state encoding used by the cache and its responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

   localparam int c_WORD_WID   = 64;
   localparam int c_LINE_WORDS = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      SEND = 2'd2
   } state_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/sram_1r1w.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1r1w
//  Description : Word storage with one synchronous read port (one-cycle
//                latency, read-first) and one write port. The read data
//                register holds its value while rd_en_i is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w #(
   parameter int WIDTH  = 64,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [WIDTH-1:0]  rd_data_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rd_data;

   // Read and write on the same edge: the read samples the pre-write contents.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         r_mem[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         r_rd_data <= r_mem[rd_addr_i];
      end
   end

   assign rd_data_o = r_rd_data;

endmodule : sram_1r1w
`default_nettype wire

// File: rtl/line_fill_responder.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_responder
//  Description : Serves cache line fills critical-word-first from a local
//                word memory, one beat per cycle with ready/valid
//                backpressure. Out-of-range requests return error beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_fill_responder
   import cache_pkg::*;
#(
   parameter int WORD_WID   = c_WORD_WID,
   parameter int LINE_WORDS = c_LINE_WORDS,
   parameter int DEPTH      = 4096,
   parameter int LATENCY    = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [31:0]              req_addr_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [WORD_WID-1:0]      rsp_data_o,
   output logic                     rsp_last_o,
   output logic                     rsp_err_o,
   input  logic                     wr_en_i,
   input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
   input  logic [WORD_WID-1:0]      wr_data_i
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LOW_W  = $clog2(LINE_WORDS);
   localparam int WAIT_W = $clog2(LATENCY + 2);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_alive;
   logic [WAIT_W-1:0]   r_wait;
   logic [LOW_W-1:0]    r_beat;
   logic [ADDR_W-1:0]   r_word;
   logic                r_err;
   logic                r_valid;
   logic                r_last;

   logic                w_accept;
   logic                w_issue;
   logic                w_req_err;
   logic [LOW_W-1:0]    w_low;
   logic [ADDR_W-1:0]   w_rd_addr;
   logic [WORD_WID-1:0] w_rd_data;
   logic                w_unused_bits;

   // Byte offset within a word carries no information for a word-granular fill.
   assign w_unused_bits = ^req_addr_i[2:0];

   assign w_req_err = {3'b000, req_addr_i[31:3]} >= 32'(DEPTH);
   assign w_accept  = req_valid_i && req_ready_o;

   // Critical-word-first: the offset advances from the missed word and wraps in the line.
   assign w_low     = r_word[LOW_W-1:0] + r_beat;
   assign w_rd_addr = {r_word[ADDR_W-1:LOW_W], w_low};

   // Next-state and beat-issue decode; a beat is read only when the output slot is free.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = WAIT;
         end
         WAIT: begin
            if (r_wait == WAIT_W'(LATENCY)) w_state_nxt = SEND;
         end
         SEND: begin
            w_issue = !r_valid || (rsp_ready_i && !r_last);
            if (r_valid && r_last && rsp_ready_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, counters, request capture and the beat qualifier registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_alive <= 1'b0;
         r_wait  <= '0;
         r_beat  <= '0;
         r_word  <= '0;
         r_err   <= 1'b0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_alive <= 1'b1;
         r_wait  <= (r_state == WAIT) ? r_wait + WAIT_W'(1) : '0;
         if (w_accept) begin
            r_word <= req_addr_i[ADDR_W+2:3];
            r_err  <= w_req_err;
            r_beat <= '0;
         end else if (w_issue) begin
            r_beat <= r_beat + LOW_W'(1);
         end
         if (w_issue) begin
            r_valid <= 1'b1;
            r_last  <= (r_beat == LOW_W'(LINE_WORDS - 1));
         end else if (r_valid && rsp_ready_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   sram_1r1w #(
      .WIDTH (WORD_WID),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
   ) u_sram (
      .clk_i    (clk_i),
      .rd_en_i  (w_issue && !r_err),
      .rd_addr_i(w_rd_addr),
      .rd_data_o(w_rd_data),
      .wr_en_i  (wr_en_i),
      .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i)
   );

   // The read register only advances on issue, so beat data holds under backpressure.
   assign req_ready_o = (r_state == IDLE) && r_alive;
   assign rsp_valid_o = r_valid;
   assign rsp_last_o  = r_last;
   assign rsp_err_o   = r_valid && r_err;
   assign rsp_data_o  = (r_valid && !r_err) ? w_rd_data : '0;

endmodule : line_fill_responder
`default_nettype wire
